// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and default constants for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_CNT_W               = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for a single asynchronous bit
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor; releases sys_rst after lock is stable
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clr_cnt,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int TMR_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);

  pll_state_e       state, state_d;
  logic [TMR_W-1:0] timer;
  logic             locked_s;
  logic             lost_inc, retry_inc;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= PLL_RESET;
      timer <= '0;
    end else begin
      state <= state_d;
      timer <= (state_d != state) ? '0 : timer + TMR_W'(1);
    end
  end

  // Lock is checked before timeout so a coincident lock is never thrown away.
  always_comb begin
    state_d   = state;
    lost_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state)
      PLL_RESET: begin
        if (timer == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (timer == TIMEOUT_LAST) begin
          state_d   = PLL_RESET;
          retry_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = PLL_RESET;
          lost_inc = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase
  end

  // Outputs decode the next state so they flip on the same edge as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      pll_rst <= (state_d == PLL_RESET);
      sys_rst <= (state_d != RUN);
      ready   <= (state_d == RUN);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || clr_cnt) begin
      lock_lost_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      if (lost_inc && (lock_lost_cnt != {CNT_W{1'b1}})) lock_lost_cnt <= lock_lost_cnt + CNT_W'(1);
      if (retry_inc && (retry_cnt != {CNT_W{1'b1}})) retry_cnt <= retry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer with directed scenarios
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       clr_cnt = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [3:0] lock_lost_cnt, retry_cnt;

  pll_lock_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(20), .CNT_W(4)
  ) dut (
    .refclk        (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clr_cnt       (clr_cnt),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt),
    .retry_cnt     (retry_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string nm;
    logic  pr;
    logic  sr;
    logic  rdy;
    int    ll;
    int    rc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic push(input int c, input string nm, input logic pr, input logic sr,
                      input logic rdy, input int ll, input int rc);
    exp_t e;
    e.cyc = c; e.nm = nm; e.pr = pr; e.sr = sr; e.rdy = rdy; e.ll = ll; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (ecnt < c) @(negedge clk);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (e.cyc != ecnt || pll_rst !== e.pr || sys_rst !== e.sr || ready !== e.rdy ||
            lock_lost_cnt !== 4'(e.ll) || retry_cnt !== 4'(e.rc)) begin
          n_fail++;
          $display("FAIL %s edge %0d (due %0d): got pll_rst=%b sys_rst=%b ready=%b lost=%0d retry=%0d, want pll_rst=%b sys_rst=%b ready=%b lost=%0d retry=%0d",
                   e.nm, ecnt, e.cyc, pll_rst, sys_rst, ready, lock_lost_cnt, retry_cnt,
                   e.pr, e.sr, e.rdy, e.ll, e.rc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    int c;
    repeat (3) @(negedge clk);

    // Lock present throughout reset release
    b = ecnt;
    push(b,      "s1_reset",     1, 1, 0, 0, 0);
    push(b + 3,  "s1_prst_hold", 1, 1, 0, 0, 0);
    push(b + 4,  "s1_wait_lock", 0, 1, 0, 0, 0);
    push(b + 5,  "s1_stabilize", 0, 1, 0, 0, 0);
    push(b + 12, "s1_pre_run",   0, 1, 0, 0, 0);
    push(b + 13, "s1_run",       0, 0, 1, 0, 0);
    rst = 1'b0;
    wait_until(b + 15);

    // Lock lost in RUN, then re-lock through the full sequence
    b = ecnt;
    pll_locked = 1'b0;
    push(b + 2,  "s4_still_run", 0, 0, 1, 0, 0);
    push(b + 3,  "s4_lost",      1, 1, 0, 1, 0);
    push(b + 6,  "s4_prst_hold", 1, 1, 0, 1, 0);
    push(b + 7,  "s4_wait_lock", 0, 1, 0, 1, 0);
    push(b + 15, "s4_pre_run",   0, 1, 0, 1, 0);
    push(b + 16, "s4_relock",    0, 0, 1, 1, 0);
    wait_until(b + 3);
    pll_locked = 1'b1;
    wait_until(b + 18);

    // clr_cnt coincides with lost 1->2, then a 1-cycle glitch at STABILIZE cycle 5
    b = ecnt;
    pll_locked = 1'b0;
    push(b + 2,  "s5_pre_clr",      0, 0, 1, 1, 0);
    push(b + 3,  "s5_clr_wins",     1, 1, 0, 0, 0);
    push(b + 7,  "s5_wait_lock",    0, 1, 0, 0, 0);
    push(b + 14, "s3_glitch",       0, 1, 0, 0, 0);
    push(b + 16, "s3_no_early_run", 0, 1, 0, 0, 0);
    push(b + 23, "s3_pre_run",      0, 1, 0, 0, 0);
    push(b + 24, "s3_run",          0, 0, 1, 0, 0);
    wait_until(b + 2);
    clr_cnt = 1'b1;
    wait_until(b + 3);
    clr_cnt = 1'b0;
    pll_locked = 1'b1;
    wait_until(b + 12);
    pll_locked = 1'b0;
    wait_until(b + 13);
    pll_locked = 1'b1;
    wait_until(b + 26);

    // One-cycle rst in the middle of STABILIZE
    b = ecnt;
    pll_locked = 1'b0;
    push(b + 3,  "s6_lost",       1, 1, 0, 1, 0);
    push(b + 10, "s6_stabilize",  0, 1, 0, 1, 0);
    push(b + 11, "s6_rst",        1, 1, 0, 0, 0);
    push(b + 14, "s6_prst_hold",  1, 1, 0, 0, 0);
    push(b + 15, "s6_wait_lock",  0, 1, 0, 0, 0);
    push(b + 23, "s6_pre_run",    0, 1, 0, 0, 0);
    push(b + 24, "s6_run",        0, 0, 1, 0, 0);
    wait_until(b + 3);
    pll_locked = 1'b1;
    wait_until(b + 10);
    rst = 1'b1;
    wait_until(b + 11);
    rst = 1'b0;
    wait_until(b + 26);

    // No lock ever: periodic PLL resets, retry_cnt saturates at 15
    pll_locked = 1'b0;
    rst = 1'b1;
    c = ecnt + 2;
    wait_until(c);
    b = ecnt;
    push(b, "s2_reset", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      push(b + 24 * k - 1, "s2_pre_timeout", 0, 1, 0, 0, sat15(k - 1));
      push(b + 24 * k,     "s2_timeout",     1, 1, 0, 0, sat15(k));
      push(b + 24 * k + 3, "s2_prst_hold",   1, 1, 0, 0, sat15(k));
      push(b + 24 * k + 4, "s2_wait_lock",   0, 1, 0, 0, sat15(k));
    end
    rst = 1'b0;
    wait_until(b + 24 * 17 + 6);

    c = ecnt + 2;
    wait_until(c);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Supervises the RX clock PLL from its reference-clock domain. It drives the PLL reset, synchronizes and qualifies the PLL `locked` flag, and re-resets the PLL on lock timeout or loss of lock. It releases a system reset to the downstream 48 MHz / 1 MHz logic only after lock has been stable for a programmable time. It sits directly beside the PLL: upstream of its `rst` input and downstream of its `locked` output.

## Interface
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2)
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held per PLL reset (≥2)
- `LOCK_STABLE_CYCLES`, 1024: cycles `locked` must stay high before release (≥2)
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles to wait for lock before re-resetting the PLL (≥2; 1 ms at 50 MHz)
- `CNT_W`, 8: width of the event counters

- `refclk` in 1: 50 MHz reference clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: PLL locked flag, asynchronous to `refclk`
- `clr_cnt` in 1: synchronous clear of both counters
- `pll_rst` out 1: reset to PLL, active-high
- `sys_rst` out 1: active-high reset for downstream logic; consumers resynchronize it into their own clock
- `ready` out 1: high only in RUN
- `lock_lost_cnt` out CNT_W: count of RUN→PLL_RESET events, saturating
- `retry_cnt` out CNT_W: count of lock timeouts, saturating

## Operation
- `locked_s` is `pll_locked` after `SYNC_STAGES` flops. `rst` clears the flops to 0.
- One shared timer, wide enough for the largest count parameter. It is cleared on every state change.

State machine:
- **PLL_RESET**
  - Outputs: `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - After `PLL_RST_CYCLES` cycles → WAIT_LOCK.
- **WAIT_LOCK**
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1 → STABILIZE.
  - Else, timer reaching `LOCK_TIMEOUT_CYCLES`-1 → PLL_RESET, and `retry_cnt`+1.
  - If lock and timeout coincide, lock wins.
- **STABILIZE**
  - Outputs: `sys_rst`=1.
  - `locked_s`=0 → WAIT_LOCK. Counters are unchanged (glitch tolerance).
  - Timer reaching `LOCK_STABLE_CYCLES`-1 with `locked_s`=1 → RUN.
- **RUN**
  - Outputs: `sys_rst`=0, `ready`=1.
  - `locked_s`=0 → PLL_RESET, and `lock_lost_cnt`+1.

Counters and outputs:
- Counters saturate at 2^CNT_W−1.
- `clr_cnt` zeroes both counters. It wins over a simultaneous increment.
- All outputs are registered Moore decodes. They change on the same edge as the state.

## Timing
- Reset values, held while `rst`=1:
  - state = PLL_RESET, timer = 0, synchronizer = 0
  - `pll_rst`=1, `sys_rst`=1, `ready`=0
  - `lock_lost_cnt`=0, `retry_cnt`=0
- `rst` asserted mid-operation: all of the above on the next edge, regardless of state.
- State occupancy:
  - PLL_RESET: exactly `PLL_RST_CYCLES` cycles.
  - STABILIZE to RUN: exactly `LOCK_STABLE_CYCLES` cycles.
  - A WAIT_LOCK timeout: exactly `LOCK_TIMEOUT_CYCLES` cycles.
- `pll_locked` rising during WAIT_LOCK → `ready` high `SYNC_STAGES`+1+`LOCK_STABLE_CYCLES` edges after the first edge that samples it high.
- `pll_locked` falling in RUN → `ready` low and `pll_rst` high `SYNC_STAGES`+1 edges after the first edge that samples it low.
- `pll_locked` pulses shorter than one `refclk` period may be missed. This is acceptable.

## Structure
- Shared package `pll_seq_pkg`:
  - state encoding: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3
  - default parameter constants
- One sub-module, `sync_bit`: a parameterized `SYNC_STAGES` flop chain with synchronous reset. Reused for other async inputs.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=20, `CNT_W`=4.

1. `pll_locked`=1 throughout, release `rst`:
   - `pll_rst` high 4 cycles after the last `rst`-high edge.
   - WAIT_LOCK lasts 1 cycle.
   - `ready`=1 and `sys_rst`=0 after 13 cycles.
2. `pll_locked`=0 forever:
   - `pll_rst` pulses 4 cycles high every 24 cycles.
   - `retry_cnt` increments once per pulse, reaches 15 and stays there.
   - `ready` never rises.
3. Lock, then drop `pll_locked` for 1 cycle at STABILIZE cycle 5:
   - FSM returns to WAIT_LOCK; both counters stay 0.
   - `ready` rises 11 edges after `pll_locked` returns high.
4. In RUN, drop `pll_locked`:
   - 3 edges later: `ready`=0, `sys_rst`=1, `pll_rst`=1, `lock_lost_cnt`=1.
   - With `pll_locked` re-asserted, the FSM re-locks through the full sequence.
5. Assert `clr_cnt` on the same edge as a `lock_lost_cnt` increment (count 1→2): count reads 0.
6. Assert `rst` for 1 cycle mid-STABILIZE: next edge shows all reset values, and the full PLL_RESET sequence restarts.
